board_sysctl: RTL



---
 rtl/board_sysctl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/board_sysctl.sv
// board_sysctl: button sync/debounce, stretched core reset with cause tracking, clock-enable divider, trap handling.
// Optional: define TRAP_AUTORESET_EN to reset the core automatically TRAP_HOLD cycles after a trap.
module board_sysctl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int RESET_CYCLES    = 16,
    parameter int CLKDIV          = 5,
    parameter int TRAP_HOLD       = 1024
) (
    input  logic       clk,
    input  logic       power_on_reset_n,
    input  logic       btn_n,
    input  logic       trap,
    output logic       sys_reset,
    output logic       clk_en,
    output logic       btn_pressed,
    output logic       trapped,
    output logic [1:0] reset_cause
);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HCW = $clog2(RESET_CYCLES) + 1;
    localparam int DVW = $clog2(CLKDIV) + 1;
    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_BTN = 2'b01;

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || RESET_CYCLES < 1 || CLKDIV < 1 || TRAP_HOLD < 1) begin : g_bad_param
        $error("board_sysctl: illegal parameter value");
    end

    typedef enum logic [1:0] {HOLD, RUN, TRAPPED} state_t;

    state_t               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DBW-1:0]       debounce_cnt_q, debounce_cnt_d;
    logic [HCW-1:0]       hold_cnt_q, hold_cnt_d;
    logic [DVW-1:0]       div_cnt_q, div_cnt_d;
    logic [1:0]           reset_cause_q, reset_cause_d;
    logic                 btn_pressed_q, btn_pressed_d;
    logic                 btn_prev_q, btn_prev_d;
    logic                 sys_reset_q, sys_reset_d;
    logic                 clk_en_q, clk_en_d;
    logic                 trapped_q, trapped_d;
    logic                 sync_pressed, btn_rise, div_wrap;
`ifdef TRAP_AUTORESET_EN
    localparam int TCW = $clog2(TRAP_HOLD) + 1;
    localparam logic [1:0] CAUSE_TRAP = 2'b10;
    logic [TCW-1:0]       trap_cnt_q, trap_cnt_d;
`endif

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], btn_n};
        sync_pressed = ~sync_q[SYNC_STAGES-1];
        btn_pressed_d  = btn_pressed_q;
        debounce_cnt_d = '0;
        if (sync_pressed != btn_pressed_q) begin
            if (debounce_cnt_q == DBW'(DEBOUNCE_CYCLES - 1))
                btn_pressed_d = ~btn_pressed_q;
            else
                debounce_cnt_d = debounce_cnt_q + 1'b1;
        end
        btn_prev_d = btn_pressed_q;
        btn_rise   = btn_pressed_q & ~btn_prev_q;
        // Free-running divider: only power-on reset touches it.
        div_wrap  = div_cnt_q == DVW'(CLKDIV - 1);
        div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
        clk_en_d  = div_wrap;
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        reset_cause_d = reset_cause_q;
`ifdef TRAP_AUTORESET_EN
        trap_cnt_d = trap_cnt_q;
`endif
        case (state_q)
            HOLD: begin
                if (btn_pressed_q)
                    hold_cnt_d = '0;
                else if (hold_cnt_q == HCW'(RESET_CYCLES - 1))
                    state_d = RUN;
                else
                    hold_cnt_d = hold_cnt_q + 1'b1;
            end
            RUN: begin
                if (btn_rise) begin
                    state_d       = HOLD;
                    hold_cnt_d    = '0;
                    reset_cause_d = CAUSE_BTN;
                end else if (trap) begin
                    state_d = TRAPPED;
`ifdef TRAP_AUTORESET_EN
                    trap_cnt_d = '0;
`endif
                end
            end
            TRAPPED: begin
                if (btn_rise) begin
                    state_d       = HOLD;
                    hold_cnt_d    = '0;
                    reset_cause_d = CAUSE_BTN;
                end
`ifdef TRAP_AUTORESET_EN
                else if (trap_cnt_q == TCW'(TRAP_HOLD - 1)) begin
                    state_d       = HOLD;
                    hold_cnt_d    = '0;
                    reset_cause_d = CAUSE_TRAP;
                end else begin
                    trap_cnt_d = trap_cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = HOLD;
        endcase
        sys_reset_d = state_d == HOLD;
        trapped_d   = state_d == TRAPPED;
    end

    always_ff @(posedge clk) begin
        if (!power_on_reset_n) begin
            state_q        <= HOLD;
            sync_q         <= '1;
            debounce_cnt_q <= '0;
            hold_cnt_q     <= '0;
            div_cnt_q      <= '0;
            reset_cause_q  <= CAUSE_POR;
            btn_pressed_q  <= 1'b0;
            btn_prev_q     <= 1'b0;
            sys_reset_q    <= 1'b1;
            clk_en_q       <= 1'b0;
            trapped_q      <= 1'b0;
`ifdef TRAP_AUTORESET_EN
            trap_cnt_q     <= '0;
`endif
        end else begin
            state_q        <= state_d;
            sync_q         <= sync_d;
            debounce_cnt_q <= debounce_cnt_d;
            hold_cnt_q     <= hold_cnt_d;
            div_cnt_q      <= div_cnt_d;
            reset_cause_q  <= reset_cause_d;
            btn_pressed_q  <= btn_pressed_d;
            btn_prev_q     <= btn_prev_d;
            sys_reset_q    <= sys_reset_d;
            clk_en_q       <= clk_en_d;
            trapped_q      <= trapped_d;
`ifdef TRAP_AUTORESET_EN
            trap_cnt_q     <= trap_cnt_d;
`endif
        end
    end

    assign sys_reset   = sys_reset_q;
    assign clk_en      = clk_en_q;
    assign btn_pressed = btn_pressed_q;
    assign trapped     = trapped_q;
    assign reset_cause = reset_cause_q;
endmodule
